dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data RAM between the core load/store path and a debug/DMA requester.
//  Grants one requester at a time and issues a single access to the RAM.
//  For the granted requester, generates byte enables and lane-replicated write data from funct3.
//  Returns the load data aligned and sign/zero-extended. Sits between the ALU/LSU stage and the RAM.
// PARAMETERS
//  STARVE_MAX  4   core-won arbitration cycles while dbg waits before dbg is forced to win (1..15)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst          in   1   asynchronous, active-high reset
//  core_req     in   1   core access request; held high until core_done
//  core_we      in   1   1=store, 0=load
//  core_addr    in   32  byte address (alignment guaranteed by ALU misalign check)
//  core_wdat    in   32  store data, valid in low bytes
//  core_funct3  in   3   RV32 load/store funct3 (000 b,001 h,010 w,100 bu,101 hu)
//  core_stall   out  1   core_req & ~core_done (combinational); freezes pipeline
//  core_done    out  1   1-cycle pulse: core access complete
//  core_rdata   out  32  extended load data, valid with core_done on loads
//  dbg_req      in   1   debug word access request (valid)
//  dbg_we       in   1   1=write, 0=read
//  dbg_addr     in   32  word address (bits[1:0] ignored)
//  dbg_wdat     in   32  write data
//  dbg_ack      out  1   1-cycle pulse: debug access complete (ready)
//  dbg_rdata    out  32  read data, valid with dbg_ack on reads
//  mem_req      out  1   RAM request, held until mem_gnt
//  mem_we       out  1   RAM write enable
//  mem_addr     out  32  {addr[31:2],2'b00}
//  mem_be       out  4   byte enables
//  mem_wdata    out  32  lane-replicated write data
//  mem_gnt      in   1   RAM accepted request this cycle
//  mem_rvalid   in   1   read data valid (>=1 cycle after gnt)
//  mem_rdata    in   32  raw RAM word
// BEHAVIOUR
//  Reset: state=IDLE, starve_cnt=0. mem_req, mem_we, mem_addr, mem_be, mem_wdata = 0.
//   core_done, dbg_ack = 0; core_rdata, dbg_rdata = 0.
//  FSM IDLE->ISSUE->(RESP)->IDLE, one outstanding access.
//  IDLE: if any request, latch owner and access fields into registers; ->ISSUE next cycle.
//  Arbitration, both pending: core wins unless starve_cnt==STARVE_MAX, then dbg wins.
//  starve_cnt: +1 on each arbitration dbg loses; cleared on dbg grant; saturates at STARVE_MAX.
//  ISSUE: mem_req=1, registered fields stable until mem_gnt.
//   On gnt: write -> done/ack pulse next cycle, ->IDLE. Read -> RESP.
//  RESP: wait mem_rvalid; capture extended data into core_rdata/dbg_rdata.
//   Pulse done/ack the following cycle; ->IDLE.
//  Min latency from req rise (gnt and rvalid immediate): write 2 cycles to done, read 3.
//  Requester must not drop req before done/ack. Requests seen after done are new accesses.
//  Core byte lane, o=addr[1:0]:
//   b: be=1<<o, wdata={4{wdat[7:0]}}
//   h: be=addr[1]?1100:0011, wdata={2{wdat[15:0]}}
//   w: be=1111
//  dbg: be=1111, wdata=dbg_wdat.
//  Load extract: byte rdata[8o+:8], half rdata[16*addr[1]+:16].
//   funct3[2]=0 sign-extend, 1 zero-extend; word unchanged.
//  Unlisted funct3 treated as word.
//  done and ack never assert in the same cycle.
//  rst mid-access: FSM->IDLE immediately, mem_req drops, no done/ack for aborted access.
//   Requester re-issues.
// TESTING
//  Core sb addr=0x103 wdat=0xAB -> mem_addr 0x100, be 1000, wdata 0xABABABAB, done 2 cycles later.
//  Core lh addr=0x102, rdata=0x80017FFF -> core_rdata 0xFFFF8001; lhu -> 0x00008001; lb addr 0x101 -> 0x0000007F.
//  Core and dbg both held high, STARVE_MAX=4 -> grants core,core,core,core,dbg; starve_cnt back to 0.
//  Read with mem_gnt delayed 3 cycles, rvalid 2 after gnt -> mem_req/addr stable; core_stall high until done.
//  dbg write 0x200=0xDEADBEEF, then dbg read 0x200 -> dbg_rdata 0xDEADBEEF, be 1111 both.
//  rst asserted during RESP of core read -> mem_req 0, no core_done; after release re-issued load completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: shares one single-port RAM between the core LSU and a
// debug/DMA word port, with store lane steering and load extension for the core.
module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdat,
    input  logic [2:0]  core_funct3,
    output logic        core_stall,
    output logic        core_done,
    output logic [31:0] core_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdat,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state, state_nxt;
    logic        own_dbg;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [3:0]  starve_cnt;
    logic        core_pend, dbg_pend, arb_ok;
    logic        grant_core, grant_dbg;
    logic [3:0]  core_be;
    logic [31:0] core_wd;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        unused_dbg_addr_lsb;

    assign unused_dbg_addr_lsb = ^dbg_addr[1:0];

    // A request whose done/ack is showing this cycle is the finished access,
    // not a new one, so it is masked from arbitration.
    assign core_pend  = core_req & ~core_done;
    assign dbg_pend   = dbg_req & ~dbg_ack;
    assign core_stall = core_req & ~core_done;
    // Arbitration waits out the done/ack cycle so a requester that holds its
    // request straight into a new access competes on equal terms.
    assign arb_ok     = (state == IDLE) & ~core_done & ~dbg_ack;
    assign grant_dbg  = arb_ok & dbg_pend & (~core_pend | (starve_cnt == 4'(STARVE_MAX)));
    assign grant_core = arb_ok & core_pend & ~grant_dbg;
    assign mem_req    = (state == ISSUE);

    // Core store lane steering: byte enables and replicated write data
    always_comb begin
        core_be = 4'b1111;
        core_wd = core_wdat;
        case (core_funct3[1:0])
            2'b00: begin
                core_be = 4'b0001 << core_addr[1:0];
                core_wd = {4{core_wdat[7:0]}};
            end
            2'b01: begin
                core_be = core_addr[1] ? 4'b1100 : 4'b0011;
                core_wd = {2{core_wdat[15:0]}};
            end
            default: ;
        endcase
    end

    // Core load extraction and sign/zero extension
    always_comb begin
        ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
        ld_ext  = mem_rdata;
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_core | grant_dbg) state_nxt = ISSUE;
            ISSUE:   if (mem_gnt) state_nxt = mem_we ? IDLE : RESP;
            RESP:    if (mem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Access latch on grant, starvation counter, completion pulses and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_dbg    <= 1'b0;
            off_q      <= '0;
            f3_q       <= '0;
            starve_cnt <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            core_done  <= 1'b0;
            dbg_ack    <= 1'b0;
            core_rdata <= '0;
            dbg_rdata  <= '0;
        end else begin
            core_done <= 1'b0;
            dbg_ack   <= 1'b0;

            if (grant_core) begin
                own_dbg   <= 1'b0;
                mem_we    <= core_we;
                mem_addr  <= {core_addr[31:2], 2'b00};
                mem_be    <= core_be;
                mem_wdata <= core_wd;
                off_q     <= core_addr[1:0];
                f3_q      <= core_funct3;
            end else if (grant_dbg) begin
                own_dbg   <= 1'b1;
                mem_we    <= dbg_we;
                mem_addr  <= {dbg_addr[31:2], 2'b00};
                mem_be    <= 4'b1111;
                mem_wdata <= dbg_wdat;
                off_q     <= 2'b00;
                f3_q      <= 3'b010;
            end

            if (grant_dbg)
                starve_cnt <= '0;
            else if (grant_core && dbg_pend && starve_cnt != 4'(STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;

            if (state == ISSUE && mem_gnt && mem_we) begin
                core_done <= ~own_dbg;
                dbg_ack   <= own_dbg;
            end

            if (state == RESP && mem_rvalid) begin
                if (own_dbg) begin
                    dbg_rdata <= mem_rdata;
                    dbg_ack   <= 1'b1;
                end else begin
                    core_rdata <= ld_ext;
                    core_done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: the bench plays the RAM and checks
// every access against expectations computed from the byte-lane rules.
module tb_dmem_arbiter;

    localparam int SM = 4;

    logic        clk, rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdat;
    logic [2:0]  core_funct3;
    logic        core_stall, core_done;
    logic [31:0] core_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdat;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] ram [0:255];

    dmem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdat(core_wdat), .core_funct3(core_funct3),
        .core_stall(core_stall), .core_done(core_done), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdat(dbg_wdat),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 4'(1 << a[1:0]);
            3'b001, 3'b101: return a[1] ? 4'b1100 : 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd(input logic [31:0] d, input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return (d & 32'hFF) * 32'h01010101;
            3'b001, 3'b101: return (d & 32'hFFFF) * 32'h00010001;
            default:        return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f);
        logic [31:0] b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f)
            3'b000:  return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Act as the RAM for one access: wait for mem_req, grant after gd cycles,
    // return read data rd cycles after the grant cycle.
    task automatic serve(input int gd, input int rd, input bit stall_chk,
                         output logic [31:0] a, output logic w,
                         output logic [3:0] b, output logic [31:0] d);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) seen = 1;
        end
        chk1("mem_req_wait", seen, 1'b1);
        a = mem_addr; w = mem_we; b = mem_be; d = mem_wdata;
        if (!seen) return;
        for (int i = 0; i < gd; i++) begin
            @(negedge clk);
            chk1("hold_req", mem_req, 1'b1);
            chk("hold_addr", mem_addr, a);
            chk("hold_be", 32'(mem_be), 32'(b));
            if (stall_chk) chk1("hold_stall", core_stall, 1'b1);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int k = 0; k < 4; k++)
            if (w && b[k]) ram[a[9:2]][8*k +: 8] = d[8*k +: 8];
        if (!w) begin
            for (int i = 0; i < rd; i++) begin
                if (stall_chk) chk1("resp_stall", core_stall, 1'b1);
                @(negedge clk);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = ram[a[9:2]];
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
    endtask

    task automatic core_op(input logic we, input logic [31:0] addr, input logic [31:0] wdat,
                           input logic [2:0] f3, input int gd, input int rd,
                           output logic [31:0] rdata_o);
        logic [31:0] a, d;
        logic w;
        logic [3:0] b;
        int t0;
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_addr = addr; core_wdat = wdat; core_funct3 = f3;
        t0 = cyc;
        serve(gd, rd, 1'b1, a, w, b, d);
        chk("core_addr", a, {addr[31:2], 2'b00});
        chk1("core_we", w, we);
        chk("core_be", 32'(b), 32'(exp_be(addr, f3)));
        if (we) chk("core_wdata", d, exp_wd(wdat, f3));
        chk1("core_done", core_done, 1'b1);
        chk1("core_no_ack", dbg_ack, 1'b0);
        chk1("core_stall_lo", core_stall, 1'b0);
        chk("core_latency", 32'(cyc - t0), we ? 32'(2 + gd) : 32'(3 + gd + rd));
        if (!we) chk("core_rdata", core_rdata, exp_load(ram[addr[9:2]], addr, f3));
        rdata_o = core_rdata;
        core_req = 1'b0;
        @(negedge clk);
        chk1("core_done_pulse", core_done, 1'b0);
    endtask

    task automatic dbg_op(input logic we, input logic [31:0] addr, input logic [31:0] wdat,
                          input int gd, input int rd, output logic [31:0] rdata_o);
        logic [31:0] a, d;
        logic w;
        logic [3:0] b;
        int t0;
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdat = wdat;
        t0 = cyc;
        serve(gd, rd, 1'b0, a, w, b, d);
        chk("dbg_addr", a, {addr[31:2], 2'b00});
        chk1("dbg_we", w, we);
        chk("dbg_be", 32'(b), 32'hF);
        if (we) chk("dbg_wdata", d, wdat);
        chk1("dbg_ack", dbg_ack, 1'b1);
        chk1("dbg_no_done", core_done, 1'b0);
        chk("dbg_latency", 32'(cyc - t0), we ? 32'(2 + gd) : 32'(3 + gd + rd));
        if (!we) chk("dbg_rdata", dbg_rdata, ram[addr[9:2]]);
        rdata_o = dbg_rdata;
        dbg_req = 1'b0;
        @(negedge clk);
        chk1("dbg_ack_pulse", dbg_ack, 1'b0);
    endtask

    initial begin
        logic [31:0] r, a, d;
        logic w;
        logic [3:0] b;
        logic [2:0] ldf [5];
        ldf[0] = 3'b000; ldf[1] = 3'b001; ldf[2] = 3'b010; ldf[3] = 3'b100; ldf[4] = 3'b101;
        for (int i = 0; i < 256; i++) ram[i] = $urandom;

        rst = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wdat = 0; core_funct3 = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdat = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_core_done", core_done, 1'b0);
        chk1("rst_dbg_ack", dbg_ack, 1'b0);
        chk("rst_core_rdata", core_rdata, 32'h0);
        chk("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk1("rst_stall", core_stall, 1'b0);
        rst = 1'b0;

        // sb / lh / lhu / lb / unlisted funct3
        core_op(1'b1, 32'h103, 32'hAB, 3'b000, 0, 0, r);
        chk("sb_ram_byte3", ram[32'h100 >> 2] >> 24, 32'hAB);
        ram[32'h100 >> 2] = 32'h80017FFF;
        core_op(1'b0, 32'h102, 32'h0, 3'b001, 0, 0, r);
        chk("lh_lit", r, 32'hFFFF8001);
        core_op(1'b0, 32'h102, 32'h0, 3'b101, 0, 0, r);
        chk("lhu_lit", r, 32'h00008001);
        core_op(1'b0, 32'h101, 32'h0, 3'b000, 0, 0, r);
        chk("lb_lit", r, 32'h0000007F);
        core_op(1'b0, 32'h100, 32'h0, 3'b111, 1, 1, r);
        chk("lunk_word", r, 32'h80017FFF);
        core_op(1'b1, 32'h106, 32'h1234C3D2, 3'b001, 1, 0, r);

        // delayed grant and rvalid
        core_op(1'b0, 32'h108, 32'h0, 3'b010, 3, 2, r);

        // debug write then read
        dbg_op(1'b1, 32'h202, 32'hDEADBEEF, 0, 0, r);
        dbg_op(1'b0, 32'h200, 32'h0, 0, 0, r);
        chk("dbg_rd_lit", r, 32'hDEADBEEF);

        // continuous contention: dbg wins every (SM+1)th grant
        @(negedge clk);
        core_req = 1; core_we = 1; core_funct3 = 3'b010; core_addr = 32'h40; core_wdat = $urandom;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h200;
        for (int k = 0; k < 2 * (SM + 1); k++) begin
            serve(0, 0, 1'b0, a, w, b, d);
            chk1("starve_dbg_owner", dbg_ack, (k % (SM + 1)) == SM);
            chk1("starve_core_owner", core_done, (k % (SM + 1)) != SM);
            if (dbg_ack) chk("starve_dbg_rdata", dbg_rdata, 32'hDEADBEEF);
            if (core_done) begin
                core_addr = core_addr + 4;
                core_wdat = $urandom;
            end
        end
        core_req = 0; dbg_req = 0;
        @(negedge clk);

        // reset during RESP of a core read
        @(negedge clk);
        core_req = 1; core_we = 0; core_addr = 32'h104; core_funct3 = 3'b010;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (mem_req === 1'b1) seen = 1;
            end
            chk1("rstmid_req_wait", seen, 1'b1);
        end
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        rst = 1;
        #1;
        chk1("rstmid_mem_req", mem_req, 1'b0);
        chk1("rstmid_done", core_done, 1'b0);
        @(negedge clk);
        chk1("rstmid_done2", core_done, 1'b0);
        chk1("rstmid_stall", core_stall, 1'b1);
        rst = 0;
        serve(0, 0, 1'b1, a, w, b, d);
        chk("rstmid_addr", a, 32'h104);
        chk1("rstmid_redo_done", core_done, 1'b1);
        chk("rstmid_rdata", core_rdata, ram[32'h104 >> 2]);
        core_req = 0;
        @(negedge clk);

        // randomized single-requester traffic
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ad;
            logic [2:0] f;
            logic wr;
            ad = {22'd0, 8'($urandom), 2'($urandom)};
            wr = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                dbg_op(wr, ad, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), r);
            end else begin
                f = wr ? 3'($urandom_range(0, 2)) : ldf[$urandom_range(0, 4)];
                if (f[1:0] == 2'b01) ad[0] = 1'b0;
                if (f[1:0] == 2'b10) ad[1:0] = 2'b00;
                core_op(wr, ad, $urandom, f, $urandom_range(0, 3), $urandom_range(0, 3), r);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
